// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter (mem_arbiter, arb_pick).
//   - arb_state_t : FSM encoding IDLE=00, GNT_I=01, GNT_D=10
//   - TIMEOUT_CYCLES_DEFAULT : default grant timeout in clock cycles
//   - GNT_I_BIT / GNT_D_BIT : bit positions in the one-hot grant vector
//   - PTR_DATA / PTR_FETCH  : round-robin pointer values (ARB_RR_EN builds)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    localparam int GNT_I_BIT = 0;
    localparam int GNT_D_BIT = 1;

    // Pointer names the port that wins the next simultaneous request.
    localparam logic PTR_DATA  = 1'b0;
    localparam logic PTR_FETCH = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Purely combinational winner selection between the fetch and data ports.
// Ports:
//   req_i : fetch port has a legal pending request
//   req_d : data port has a legal pending request
//   ptr   : port favoured on a tie (PTR_DATA or PTR_FETCH)
//   gnt   : one-hot grant, gnt[GNT_I_BIT] = fetch, gnt[GNT_D_BIT] = data
// ---------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req_i && req_d) begin
            if (ptr == PTR_FETCH) begin
                gnt[GNT_I_BIT] = 1'b1;
            end else begin
                gnt[GNT_D_BIT] = 1'b1;
            end
        end else begin
            gnt[GNT_I_BIT] = req_i;
            gnt[GNT_D_BIT] = req_d;
        end
    end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data load/store port onto one
// shared memory system. One transaction at a time; at least one IDLE cycle
// between transactions. A grant that waits TIMEOUT_CYCLES cycles without
// m_done is terminated with a done pulse and an arb_err pulse.
//
// Optional feature: define ARB_RR_EN for round-robin tie breaking (a 1-bit
// pointer that moves to the other port after each completed grant). Without
// it the data port always wins a tie.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_rd, i_addr                     fetch read request
//   i_data_out, i_done, i_stall      fetch return path
//   d_rd, d_wr, d_addr, d_data_in    data request (rd and wr together = illegal)
//   d_data_out, d_done, d_stall      data return path
//   m_addr, m_data_in, m_rd, m_wr    registered drive to the memory system
//   m_data_out, m_done, m_stall,
//   m_err                            memory system responses
//   arb_err                          pulse on timeout, illegal request, m_err
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    input  logic        m_err,
    output logic        arb_err
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t  state_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] cnt_reg;
    logic        rd_reg;
    logic        wr_reg;
    logic        ill_seen_reg;  // illegal request already flagged
    logic        run_reg;       // low until the first edge after reset release

    logic        ptr;
    logic [1:0]  gnt;
    logic        d_req_ok;
    logic        d_illegal;
    logic        in_gnt_i;
    logic        in_gnt_d;
    logic        in_gnt;
    logic        timeout_hit;
    logic        xfer_end;

`ifdef ARB_RR_EN
    logic ptr_reg;
    assign ptr = ptr_reg;
`else
    assign ptr = PTR_DATA;
`endif

    // m_stall has no effect on arbitration: the timeout counts all cycles.
    logic unused_m_stall;
    assign unused_m_stall = m_stall;

    assign d_illegal = d_rd & d_wr;
    assign d_req_ok  = d_rd ^ d_wr;

    arb_pick u_pick (
        .req_i (i_rd),
        .req_d (d_req_ok),
        .ptr   (ptr),
        .gnt   (gnt)
    );

    assign in_gnt_i    = (state_reg == GNT_I);
    assign in_gnt_d    = (state_reg == GNT_D);
    assign in_gnt      = in_gnt_i | in_gnt_d;
    // cnt_reg is the number of completed GNT cycles, so the Nth GNT cycle
    // sees N-1 here.
    assign timeout_hit = in_gnt & ~m_done & (cnt_reg == TIMEOUT_LAST);
    assign xfer_end    = in_gnt & (m_done | timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            ill_seen_reg <= 1'b0;
            run_reg      <= 1'b0;
`ifdef ARB_RR_EN
            ptr_reg      <= PTR_DATA;
`endif
        end else begin
            run_reg      <= 1'b1;
            ill_seen_reg <= d_illegal;
            case (state_reg)
                IDLE: begin
                    if (gnt[GNT_D_BIT]) begin
                        state_reg <= GNT_D;
                        addr_reg  <= d_addr;
                        wdata_reg <= d_data_in;
                        rd_reg    <= d_rd;
                        wr_reg    <= d_wr;
                        cnt_reg   <= '0;
                    end else if (gnt[GNT_I_BIT]) begin
                        state_reg <= GNT_I;
                        addr_reg  <= i_addr;
                        wdata_reg <= '0;
                        rd_reg    <= 1'b1;
                        wr_reg    <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (xfer_end) begin
                        state_reg <= IDLE;
                        rd_reg    <= 1'b0;
                        wr_reg    <= 1'b0;
`ifdef ARB_RR_EN
                        ptr_reg   <= in_gnt_d ? PTR_FETCH : PTR_DATA;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rd_reg    <= 1'b0;
                    wr_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign m_addr     = addr_reg;
    assign m_data_in  = wdata_reg;
    assign m_rd       = rd_reg;
    assign m_wr       = wr_reg;

    assign i_done     = in_gnt_i & (m_done | timeout_hit);
    assign d_done     = in_gnt_d & (m_done | timeout_hit);
    assign i_data_out = in_gnt_i ? m_data_out : '0;
    assign d_data_out = in_gnt_d ? m_data_out : '0;

    // Stall and error outputs are held low until the arbiter has left reset.
    assign i_stall    = run_reg & i_rd & ~i_done;
    assign d_stall    = run_reg & (d_rd | d_wr) & ~d_done;
    assign arb_err    = run_reg & ((in_gnt & m_err) | timeout_hit |
                                   (d_illegal & ~ill_seen_reg));

endmodule : mem_arbiter
